// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Instruction-memory channel between the fetch unit and the instruction
//   memory. The fetch unit uses the master modport.
//   req    : master -> slave  request valid
//   addr   : master -> slave  word address, bits [1:0] always zero
//   gnt    : slave -> master  request accepted this cycle
//   rvalid : slave -> master  response valid
//   rdata  : slave -> master  response instruction word
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Keeps at most one instruction-memory request in
//   flight, feeds the decode-stage register and absorbs one response in a
//   skid buffer while decode is stalled. Redirects from execute flush the
//   buffer and the decode register and discard any in-flight response.
//
//   Ports
//   clk            : clock, all state updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   stall_f        : hold the fetch PC and issue no new request
//   stall_d        : hold the decode-stage outputs
//   redirect_valid : taken branch or jump resolved in execute
//   redirect_pc    : new fetch target (bits [1:0] ignored)
//   imem           : instruction-memory channel (master side)
//   instr_d, pc_d  : decode-stage instruction and its PC
//   valid_d        : decode stage holds a real instruction
//
//   The skid buffer holds a single entry: the hazard logic is expected to
//   raise stall_f whenever it raises stall_d, so no new request can be
//   issued while a buffered response is waiting.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_f,
  input  logic         stall_d,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master imem,
  output logic [31:0]  instr_d,
  output logic [31:0]  pc_d,
  output logic         valid_d
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,  // no request outstanding
    WAIT  = 2'd1,  // one request outstanding
    KILL  = 2'd2   // outstanding response will be discarded
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_f;
  logic [31:0] pc_q;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        rsp_hit;
  logic        accept;
  logic        grant;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Request and response qualification
  always_comb begin
    rsp_hit   = (state_q == WAIT) && imem.rvalid;
    imem.req  = rst_n && ((state_q == ISSUE) || rsp_hit) &&
                !stall_f && !buf_valid && !redirect_valid;
    imem.addr = align_word(pc_f);
    accept    = rsp_hit && !redirect_valid;
    grant     = imem.req && imem.gnt;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE: begin
        if (grant) state_d = WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          state_d = imem.rvalid ? ISSUE : KILL;
        end else if (imem.rvalid) begin
          state_d = grant ? WAIT : ISSUE;
        end
      end
      KILL: begin
        // The stale response retires the outstanding request even if a new
        // redirect arrives in the same cycle; waiting on would never end.
        if (imem.rvalid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ISSUE;
    else        state_q <= state_d;
  end

  // Fetch PC, skid buffer and decode-stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f      <= align_word(RESET_PC);
      pc_q      <= '0;
      buf_valid <= 1'b0;
      buf_instr <= '0;
      buf_pc    <= '0;
      instr_d   <= NOP_INSTR;
      pc_d      <= '0;
      valid_d   <= 1'b0;
    end else if (redirect_valid) begin
      pc_f      <= align_word(redirect_pc);
      buf_valid <= 1'b0;
      instr_d   <= NOP_INSTR;
      valid_d   <= 1'b0;
    end else begin
      if (grant) begin
        pc_q <= pc_f;
        pc_f <= pc_f + 32'd4;
      end
      if (!stall_d) begin
        if (buf_valid) begin
          // Drain the older buffered entry first; a response arriving in
          // the same cycle takes its place.
          instr_d   <= buf_instr;
          pc_d      <= buf_pc;
          valid_d   <= 1'b1;
          buf_valid <= accept;
          if (accept) begin
            buf_instr <= imem.rdata;
            buf_pc    <= pc_q;
          end
        end else if (accept) begin
          instr_d <= imem.rdata;
          pc_d    <= pc_q;
          valid_d <= 1'b1;
        end else begin
          instr_d <= NOP_INSTR;
          valid_d <= 1'b0;
        end
      end else if (accept) begin
        buf_valid <= 1'b1;
        buf_instr <= imem.rdata;
        buf_pc    <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f, stall_d, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d, pc_d;
  logic        valid_d;

  always #5 clk = ~clk;

  fetch_unit_if imem();

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem          (imem),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .valid_d       (valid_d)
  );

  int errors = 0;
  int checks = 0;

  // Stimulus knobs, set by the main sequence
  bit          k_rand = 1'b0;
  bit          k_sf = 1'b0, k_sd = 1'b0, k_rd = 1'b0;
  logic [31:0] k_rpc = '0;
  int          k_gnt_pct = 100;
  int          k_lat_min = 1, k_lat_max = 1;

  // Inputs for the next cycle, applied shortly after the rising edge
  logic        nx_sf = 0, nx_sd = 0, nx_rd = 0, nx_gnt = 0, nx_rv = 0;
  logic [31:0] nx_rpc = '0, nx_rdata = '0;

  // Memory model and reference model state
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t        exp_q[$];
  bit          mem_pend = 0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  logic [31:0] next_fetch = RESET_PC;
  bit          loaded_last = 0, redir_last = 0, have_prev = 0, hold_chk = 0;
  logic [31:0] hold_addr = '0, prev_instr = '0, prev_pc = '0;
  logic        prev_valid = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs 2ns after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      stall_f        = nx_sf;
      stall_d        = nx_sd;
      redirect_valid = nx_rd;
      redirect_pc    = nx_rpc;
      imem.gnt       = nx_gnt;
      imem.rvalid    = nx_rv;
      imem.rdata     = nx_rdata;
    end
  end

  // Monitor, scoreboard and memory model, evaluated on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (imem.rvalid) mem_pend = 0;
      if (!rst_n) begin
        exp_q.delete();
        next_fetch  = RESET_PC;
        loaded_last = 0;
        redir_last  = 0;
        have_prev   = 0;
        hold_chk    = 0;
      end else begin
        if (loaded_last) begin
          if (redir_last) begin
            chk("redirect_bubble_valid", {31'b0, valid_d}, 32'd0);
            chk("redirect_bubble_instr", instr_d, NOP);
          end else if (valid_d) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_instr: got pc_d=%h, expected no valid instruction", pc_d);
            end else begin
              e = exp_q.pop_front();
              chk("decode_pc", pc_d, e.pc);
              chk("decode_instr", instr_d, e.instr);
            end
          end
        end else if (have_prev) begin
          chk("hold_instr", instr_d, prev_instr);
          chk("hold_pc", pc_d, prev_pc);
          chk("hold_valid", {31'b0, valid_d}, {31'b0, prev_valid});
        end
        if (hold_chk && !stall_f && !redirect_valid) begin
          chk("req_held", {31'b0, imem.req}, 32'd1);
          chk("addr_held", imem.addr, hold_addr);
        end
        hold_chk  = imem.req && !imem.gnt;
        hold_addr = imem.addr;
        if (imem.req) chk("addr_align", {30'b0, imem.addr[1:0]}, 32'd0);
        if (imem.req && imem.gnt) begin
          if (mem_pend) begin
            checks++;
            errors++;
            $display("FAIL outstanding: got a second grant at %h, expected at most one outstanding", imem.addr);
          end
          chk("fetch_addr", imem.addr, next_fetch);
          exp_q.push_back('{next_fetch, memf(next_fetch)});
          next_fetch = next_fetch + 32'd4;
          mem_pend = 1;
          mem_addr = imem.addr;
          mem_cnt  = int'($urandom_range(k_lat_max, k_lat_min));
        end
        if (redirect_valid) begin
          exp_q.delete();
          next_fetch = redirect_pc & 32'hFFFF_FFFC;
        end
        loaded_last = !stall_d || redirect_valid;
        redir_last  = redirect_valid;
        prev_instr  = instr_d;
        prev_pc     = pc_d;
        prev_valid  = valid_d;
        have_prev   = 1;
      end
      // Next-cycle memory response
      nx_rv    = 0;
      nx_rdata = $urandom;
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt <= 0) begin
          nx_rv    = 1;
          nx_rdata = memf(mem_addr);
        end
      end
      // Next-cycle control inputs; stall_d always comes with stall_f
      if (k_rand) begin
        nx_sd  = ($urandom % 100) < 12;
        nx_sf  = nx_sd || (($urandom % 100) < 10);
        nx_rd  = ($urandom % 100) < 4;
        nx_rpc = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
      end else begin
        nx_sd  = k_sd;
        nx_sf  = k_sf;
        nx_rd  = k_rd;
        nx_rpc = k_rpc;
      end
      nx_gnt = int'($urandom_range(99, 0)) < k_gnt_pct;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #4;
  endtask

  task automatic wait_grant(output logic [31:0] a);
    int n = 0;
    while (!(imem.req && imem.gnt) && n < 60) begin
      cyc();
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant in 60 cycles, expected a grant");
    end
    a = imem.addr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int n;
    stall_f = 0; stall_d = 0; redirect_valid = 0; redirect_pc = '0;
    imem.gnt = 0; imem.rvalid = 0; imem.rdata = '0;

    // Reset values
    repeat (3) cyc();
    chk("rst_req", {31'b0, imem.req}, 32'd0);
    chk("rst_valid", {31'b0, valid_d}, 32'd0);
    chk("rst_instr", instr_d, NOP);
    chk("rst_pc_d", pc_d, 32'd0);

    // Back-to-back fetch from reset, 1-cycle memory
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    chk("first_req", {31'b0, imem.req}, 32'd1);
    chk("first_addr", imem.addr, RESET_PC);
    cyc();
    chk("seq_req1", {31'b0, imem.req}, 32'd1);
    chk("seq_addr1", imem.addr, RESET_PC + 32'd4);
    cyc();
    chk("seq_req2", {31'b0, imem.req}, 32'd1);
    chk("seq_addr2", imem.addr, RESET_PC + 32'd8);
    chk("seq_valid_d", {31'b0, valid_d}, 32'd1);
    chk("seq_pc_d", pc_d, RESET_PC);
    repeat (4) cyc();

    // Stall both stages while a response arrives
    wait_grant(a);
    k_sf = 1; k_sd = 1;
    cyc();
    chk("stall_no_req1", {31'b0, imem.req}, 32'd0);
    cyc();
    chk("stall_no_req2", {31'b0, imem.req}, 32'd0);
    k_sf = 0; k_sd = 0;
    cyc();
    chk("buf_blocks_req", {31'b0, imem.req}, 32'd0);
    cyc();
    chk("buf_valid_d", {31'b0, valid_d}, 32'd1);
    chk("buf_pc_d", pc_d, a);
    chk("buf_instr_d", instr_d, memf(a));
    chk("resume_req", {31'b0, imem.req}, 32'd1);
    chk("resume_addr", imem.addr, a + 32'd4);

    // Redirect while waiting on a slow response
    k_lat_min = 3; k_lat_max = 3;
    cyc();
    wait_grant(a);
    k_rd = 1; k_rpc = 32'h0000_0100;
    cyc();
    k_rd = 0;
    cyc();
    chk("kill_no_req", {31'b0, imem.req}, 32'd0);
    chk("kill_valid1", {31'b0, valid_d}, 32'd0);
    cyc();
    chk("kill_drop_req", {31'b0, imem.req}, 32'd0);
    chk("kill_valid2", {31'b0, valid_d}, 32'd0);
    k_lat_min = 1; k_lat_max = 1;
    cyc();
    chk("kill_valid3", {31'b0, valid_d}, 32'd0);
    chk("kill_next_req", {31'b0, imem.req}, 32'd1);
    chk("kill_next_addr", imem.addr, 32'h0000_0100);

    // Redirect coinciding with a response under decode stall
    cyc();
    wait_grant(a);
    k_rd = 1; k_rpc = 32'h0000_0200; k_sd = 1; k_sf = 1;
    cyc();
    k_rd = 0; k_sd = 0; k_sf = 0;
    cyc();
    chk("rdrsp_req", {31'b0, imem.req}, 32'd1);
    chk("rdrsp_addr", imem.addr, 32'h0000_0200);
    chk("rdrsp_valid1", {31'b0, valid_d}, 32'd0);
    cyc();
    chk("rdrsp_valid2", {31'b0, valid_d}, 32'd0);
    cyc();
    chk("rdrsp_valid3", {31'b0, valid_d}, 32'd1);
    chk("rdrsp_pc_d", pc_d, 32'h0000_0200);

    // Address wrap and redirect alignment
    k_rd = 1; k_rpc = 32'hFFFF_FFFC;
    cyc();
    k_rd = 0;
    wait_grant(a);
    chk("wrap_top_addr", a, 32'hFFFF_FFFC);
    cyc();
    wait_grant(a);
    chk("wrap_addr", a, 32'h0000_0000);
    k_rd = 1; k_rpc = 32'h0000_0103;
    cyc();
    k_rd = 0;
    wait_grant(a);
    chk("align_addr", a, 32'h0000_0100);

    // Grant withheld for three cycles
    k_gnt_pct = 0;
    cyc();
    n = 0;
    while (!imem.req && n < 20) begin
      cyc();
      n++;
    end
    a = imem.addr;
    repeat (3) begin
      cyc();
      chk("nogrant_req", {31'b0, imem.req}, 32'd1);
      chk("nogrant_addr", imem.addr, a);
    end
    k_gnt_pct = 100;
    cyc();
    chk("late_grant", {31'b0, imem.req && imem.gnt}, 32'd1);
    chk("late_grant_addr", imem.addr, a);

    // Randomized traffic
    k_rand = 1; k_gnt_pct = 70; k_lat_min = 1; k_lat_max = 3;
    repeat (1500) cyc();

    // Reset while a request is outstanding; the late response is ignored
    k_rand = 0; k_sf = 0; k_sd = 0; k_rd = 0; k_gnt_pct = 100;
    k_lat_min = 3; k_lat_max = 3;
    cyc();
    wait_grant(a);
    k_gnt_pct = 0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #3;
    chk("midrst_req", {31'b0, imem.req}, 32'd0);
    chk("midrst_valid", {31'b0, valid_d}, 32'd0);
    chk("midrst_instr", instr_d, NOP);
    chk("midrst_pc_d", pc_d, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    chk("postrst_req", {31'b0, imem.req}, 32'd1);
    chk("postrst_addr", imem.addr, RESET_PC);
    cyc();
    chk("late_rvalid_seen", {31'b0, imem.rvalid}, 32'd1);
    chk("late_rvalid_req", {31'b0, imem.req}, 32'd1);
    chk("late_rvalid_addr", imem.addr, RESET_PC);
    k_gnt_pct = 100;
    cyc();
    chk("late_rvalid_ignored", {31'b0, valid_d}, 32'd0);
    repeat (4) cyc();
    chk("postrst_valid_d", {31'b0, valid_d}, 32'd1);
    chk("postrst_pc_d", pc_d, RESET_PC);

    k_rand = 1; k_gnt_pct = 60; k_lat_min = 1; k_lat_max = 3;
    repeat (1000) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
